mult_div_unit: RTL



---
 rtl/mips_pkg.sv | 26 ++
 rtl/mdu_divider.sv | 62 ++++++
 rtl/mult_div_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the HI/LO multiply-divide unit.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } mdu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_t;

  localparam int MDU_DIV_STEPS = 32;

  function automatic logic mdu_is_div(input mdu_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// quotient/remainder/done describe the step taken at the current edge.
module mdu_divider
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  logic             r_run;
  logic [5:0]       r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_dvs;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // The extra top bit of w_diff is the borrow of the trial subtraction.
  assign w_rem_sh  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_diff    = {1'b0, w_rem_sh} - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[WIDTH+1];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH:0] : w_rem_sh;
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  assign quotient  = w_quo_nxt;
  assign remainder = w_rem_nxt[WIDTH-1:0];
  assign done      = r_run && (r_cnt == 6'(MDU_DIV_STEPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= dividend;
      r_dvs <= {1'b0, divisor};
    end else if (r_run) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 6'd1;
      if (done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: single-cycle MULT/MULTU/MTHI/MTLO and a
// 32-cycle iterative DIV/DIVU whose busy output stalls the core.
//
// state  | meaning
// S_IDLE | accepting ops; multiplies and moves complete at the accept edge
// S_RUN  | divide in flight; busy=1, HI/LO frozen, new ops ignored
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             div_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t r_state, w_state_nxt;

  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_div_done;
  logic             r_qneg, r_rneg, r_div0;
  logic [WIDTH-1:0] r_rs_orig;

  logic               w_accept, w_start_div, w_signed_div;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
  logic [WIDTH-1:0]   w_quo, w_rem, w_q_fix, w_r_fix;
  logic               w_div_last;

  assign w_accept     = op_valid && (r_state == S_IDLE);
  assign w_start_div  = w_accept && mdu_is_div(op);
  assign w_signed_div = (op == OP_DIV);

  // Magnitude of 0x80000000 is itself when read as unsigned, so no overflow.
  assign w_a_neg = w_signed_div && rs_data[WIDTH-1];
  assign w_b_neg = w_signed_div && rt_data[WIDTH-1];
  assign w_a_mag = w_a_neg ? (WIDTH'(0) - rs_data) : rs_data;
  assign w_b_mag = w_b_neg ? (WIDTH'(0) - rt_data) : rt_data;

  assign w_prod_s = $signed({{WIDTH{rs_data[WIDTH-1]}}, rs_data}) *
                    $signed({{WIDTH{rt_data[WIDTH-1]}}, rt_data});
  assign w_prod_u = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (w_start_div),
    .dividend  (w_a_mag),
    .divisor   (w_b_mag),
    .quotient  (w_quo),
    .remainder (w_rem),
    .done      (w_div_last)
  );

  assign w_q_fix = r_qneg ? (WIDTH'(0) - w_quo) : w_quo;
  assign w_r_fix = r_rneg ? (WIDTH'(0) - w_rem) : w_rem;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start_div) w_state_nxt = S_RUN;
      S_RUN:  if (w_div_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_div0    <= 1'b0;
      r_rs_orig <= '0;
    end else if (w_start_div) begin
      r_qneg    <= w_a_neg ^ w_b_neg;
      r_rneg    <= w_a_neg;
      r_div0    <= (rt_data == '0);
      r_rs_orig <= rs_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_done <= 1'b0;
    end else begin
      r_div_done <= w_div_last;
      if (w_div_last) begin
        // Divide by zero reports the raw dividend and an all-ones quotient.
        if (r_div0) begin
          r_hi <= r_rs_orig;
          r_lo <= '1;
        end else begin
          r_hi <= w_r_fix;
          r_lo <= w_q_fix;
        end
      end else if (w_accept) begin
        case (op)
          OP_MULT:  {r_hi, r_lo} <= w_prod_s;
          OP_MULTU: {r_hi, r_lo} <= w_prod_u;
          OP_MTHI:  r_hi <= rs_data;
          OP_MTLO:  r_lo <= rs_data;
          default: ;
        endcase
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign div_done = r_div_done;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
